bcd_display_driver: RTL and testbench

Downstream stage of the 8-bit calculator ALU. Accepts the 16-bit ALU result and status flag on a start strobe and converts the result to five BCD digits with a sequential double-dabble engine, one bit per clock. It then time-multiplexes the lower four digits onto a common-anode 4-digit seven-segment display. Decimal points mark the ALU status flag and values above 9999.

---
 rtl/bcd_display_driver_if.sv | 31 +++
 rtl/bcd_display_driver.sv | 183 ++++++++++++++++++
 tb/tb_bcd_display_driver.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_driver_if
// Brief    : Request/result bundle between the ALU side and the BCD display
//            driver: value/flag/start in, conversion status, BCD result and
//            seven-segment scan signals out.
// Revision : 1.0  initial release
// ============================================================================
interface bcd_display_driver_if;
    logic [15:0] value;
    logic        flag;
    logic        start;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        flag_q;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value, flag, start,
        input  busy, done, bcd, flag_q, an, seg, dp
    );

    modport slave (
        input  value, flag, start,
        output busy, done, bcd, flag_q, an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_driver
// Brief    : Sequential double-dabble binary-to-BCD converter (one bit per
//            clock) feeding a multiplexed common-anode 4-digit seven-segment
//            display with leading-zero blanking and status decimal points.
// Revision : 1.0  initial release
// ============================================================================
module bcd_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  wire                  clk,
    input  wire                  rst_n,
    bcd_display_driver_if.slave  bus
);

    localparam int c_CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CW-1:0] c_REFRESH_LAST = c_CW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [19:0] scratch_q;
    logic        flag_int_q;
    logic [3:0]  bitcnt_q;
    logic [19:0] bcd_q;
    logic        flag_out_q;
    logic        done_q;

    logic [19:0] w_adj;
    logic [19:0] w_scratch_d;
    logic        w_last;
    logic [19:0] bcd_d;
    logic        flag_q_d;

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB
    always_comb begin
        w_adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        w_scratch_d = {w_adj[18:0], shift_q[15]};
        w_last      = (state_q == S_CONV) && (bitcnt_q == 4'd15);
        bcd_d       = w_last ? w_scratch_d : bcd_q;
        flag_q_d    = w_last ? flag_int_q  : flag_out_q;
    end

    // Conversion FSM: capture on start, 16 shift steps, publish result with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            flag_int_q <= 1'b0;
            bitcnt_q   <= '0;
            bcd_q      <= '0;
            flag_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            bcd_q      <= bcd_d;
            flag_out_q <= flag_q_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        shift_q    <= bus.value;
                        scratch_q  <= '0;
                        flag_int_q <= bus.flag;
                        bitcnt_q   <= '0;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    scratch_q <= w_scratch_d;
                    shift_q   <= {shift_q[14:0], 1'b0};
                    bitcnt_q  <= bitcnt_q + 4'd1;
                    if (w_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [c_CW-1:0] refresh_q;
    logic [c_CW-1:0] refresh_d;
    logic [1:0]      sel_q;
    logic [1:0]      sel_d;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;

    logic [3:0]      w_nib;
    logic [3:0]      w_lz;
    logic            w_blank;
    logic [6:0]      w_seg;
    logic            w_dp;

    // Next scan position; display outputs are built from next-state values so
    // the registered outputs line up with sel/bcd of the same cycle
    always_comb begin
        if (refresh_q == c_REFRESH_LAST) begin
            refresh_d = '0;
            sel_d     = sel_q + 2'd1;
        end else begin
            refresh_d = refresh_q + 1'b1;
            sel_d     = sel_q;
        end

        case (sel_d)
            2'd0:    w_nib = bcd_d[3:0];
            2'd1:    w_nib = bcd_d[7:4];
            2'd2:    w_nib = bcd_d[11:8];
            default: w_nib = bcd_d[15:12];
        endcase

        // w_lz[k]: digit k and every digit above it up to digit 3 are zero
        w_lz[3] = (bcd_d[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (bcd_d[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (bcd_d[7:4] == 4'd0);
        w_lz[0] = 1'b0;
        w_blank = (BLANK_LZ != 0) && w_lz[sel_d];

        case (w_nib)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        if (w_blank) begin
            w_seg = 7'b1111111;
        end

        w_dp = !(((sel_d == 2'd0) && flag_q_d) ||
                 ((sel_d == 2'd3) && (bcd_d[19:16] != 4'd0)));
    end

    // Refresh counter, digit select and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            sel_q     <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
            dp_q      <= 1'b1;
        end else begin
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            an_q      <= ~(4'b0001 << sel_d);
            seg_q     <= w_seg;
            dp_q      <= w_dp;
        end
    end

    assign bus.busy   = (state_q == S_CONV);
    assign bus.done   = done_q;
    assign bus.bcd    = bcd_q;
    assign bus.flag_q = flag_out_q;
    assign bus.an     = an_q;
    assign bus.seg    = seg_q;
    assign bus.dp     = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_driver
// Brief    : Self-checking bench for bcd_display_driver; expected BCD and
//            display values come from decimal arithmetic on the input value.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_display_driver;

    localparam int RD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_display_driver_if bus ();

    bcd_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned edges;
    int unsigned m_val  = 0;
    logic        m_flag = 1'b0;
    int unsigned pw [5] = '{1, 10, 100, 1000, 10000};

    // Clock edges since reset release; drives the expected scan position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [19:0] exp_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pw[k]) % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int unsigned d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.value = '0; bus.flag = 1'b0;
        #12;
        n_cmp++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)  begin n_err++; $display("FAIL rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.bcd !== 20'h0)  begin n_err++; $display("FAIL rst_bcd got %h want 00000", bus.bcd); end
        n_cmp++; if (bus.flag_q !== 1'b0) begin n_err++; $display("FAIL rst_flag_q got %b want 0", bus.flag_q); end
        n_cmp++; if (bus.an !== 4'b1110) begin n_err++; $display("FAIL rst_an got %b want 1110", bus.an); end
        n_cmp++; if (bus.seg !== 7'b1000000) begin n_err++; $display("FAIL rst_seg got %b want 1000000", bus.seg); end
        n_cmp++; if (bus.dp !== 1'b1)    begin n_err++; $display("FAIL rst_dp got %b want 1", bus.dp); end
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 0; m_flag = 1'b0;
    endtask

    task automatic test_scan(input int cycles);
        int unsigned sel, dig;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            sel   = (edges / RD) % 4;
            dig   = (m_val / pw[sel]) % 10;
            e_an  = ~(4'b0001 << sel);
            e_seg = (sel != 0 && ((m_val / pw[sel]) % pw[4 - sel]) == 0) ? 7'b1111111 : seg_of(dig);
            e_dp  = !((sel == 0 && m_flag) || (sel == 3 && m_val >= 10000));
            n_cmp++; if (bus.an !== e_an)   begin n_err++; $display("FAIL scan_an val=%0d got %b want %b", m_val, bus.an, e_an); end
            n_cmp++; if (bus.seg !== e_seg) begin n_err++; $display("FAIL scan_seg val=%0d sel=%0d got %b want %b", m_val, sel, bus.seg, e_seg); end
            n_cmp++; if (bus.dp !== e_dp)   begin n_err++; $display("FAIL scan_dp val=%0d sel=%0d got %b want %b", m_val, sel, bus.dp, e_dp); end
        end
    endtask

    task automatic run_conv(input logic [15:0] v, input logic f);
        @(negedge clk);
        bus.value = v; bus.flag = f; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.value = 16'($urandom); bus.flag = 1'($urandom);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL conv_busy v=%0d cyc=%0d got %b want 1", v, i, bus.busy); end
            n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL conv_early_done v=%0d cyc=%0d got %b want 0", v, i, bus.done); end
            n_cmp++; if (bus.bcd !== exp_bcd(m_val)) begin n_err++; $display("FAIL conv_hold_bcd v=%0d cyc=%0d got %h want %h", v, i, bus.bcd, exp_bcd(m_val)); end
        end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL conv_end_busy v=%0d got %b want 0", v, bus.busy); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL conv_done v=%0d got %b want 1", v, bus.done); end
        n_cmp++; if (bus.bcd !== exp_bcd(v)) begin n_err++; $display("FAIL conv_bcd v=%0d got %h want %h", v, bus.bcd, exp_bcd(v)); end
        n_cmp++; if (bus.flag_q !== f) begin n_err++; $display("FAIL conv_flag_q v=%0d got %b want %b", v, bus.flag_q, f); end
        m_val = v; m_flag = f;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL conv_done_pulse v=%0d got %b want 0", v, bus.done); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_conv(16'($urandom_range(0, 65535)), 1'($urandom));
            test_scan(16);
        end
    endtask

    task automatic test_back_to_back();
        logic        e_busy, e_done;
        logic [19:0] e_bcd;
        @(negedge clk);
        bus.value = 16'd100; bus.flag = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            if (c > 0) @(negedge clk);
            e_busy = (c < 16) || (c >= 17 && c < 33);
            e_done = (c == 16) || (c == 33);
            if (c == 16) begin m_val = 100; m_flag = 1'b0; end
            if (c == 33) begin m_val = 999; m_flag = 1'b0; end
            e_bcd = exp_bcd(m_val);
            n_cmp++; if (bus.busy !== e_busy) begin n_err++; $display("FAIL b2b_busy c=%0d got %b want %b", c, bus.busy, e_busy); end
            n_cmp++; if (bus.done !== e_done) begin n_err++; $display("FAIL b2b_done c=%0d got %b want %b", c, bus.done, e_done); end
            n_cmp++; if (bus.bcd !== e_bcd)   begin n_err++; $display("FAIL b2b_bcd c=%0d got %h want %h", c, bus.bcd, e_bcd); end
            bus.start = 1'b0;
            if (c == 4)  begin bus.value = 16'd999; bus.flag = 1'b1; bus.start = 1'b1; end
            if (c == 16) begin bus.value = 16'd999; bus.flag = 1'b0; bus.start = 1'b1; end
        end
    endtask

    task automatic test_reset_mid();
        run_conv(16'd8765, 1'b1);
        @(negedge clk);
        bus.value = 16'd4321; bus.flag = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)  begin n_err++; $display("FAIL mid_rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.bcd !== 20'h0)  begin n_err++; $display("FAIL mid_rst_bcd got %h want 00000", bus.bcd); end
        n_cmp++; if (bus.flag_q !== 1'b0) begin n_err++; $display("FAIL mid_rst_flag_q got %b want 0", bus.flag_q); end
        n_cmp++; if (bus.an !== 4'b1110) begin n_err++; $display("FAIL mid_rst_an got %b want 1110", bus.an); end
        n_cmp++; if (bus.seg !== 7'b1000000) begin n_err++; $display("FAIL mid_rst_seg got %b want 1000000", bus.seg); end
        n_cmp++; if (bus.dp !== 1'b1)    begin n_err++; $display("FAIL mid_rst_dp got %b want 1", bus.dp); end
        m_val = 0; m_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL post_rst_idle i=%0d got busy=%b done=%b want 0/0", i, bus.busy, bus.done); end
        end
        n_cmp++; if (bus.bcd !== 20'h0) begin n_err++; $display("FAIL post_rst_bcd got %h want 00000", bus.bcd); end
        run_conv(16'd4321, 1'b0);
        test_scan(16);
    endtask

    initial begin
        test_reset();
        test_scan(16);
        run_conv(16'd1234, 1'b0);
        test_scan(16);
        run_conv(16'd65535, 1'b1);
        test_scan(16);
        run_conv(16'd7, 1'b0);
        test_scan(16);
        run_conv(16'd0, 1'b0);
        test_scan(16);
        run_conv(16'd10000, 1'b0);
        test_scan(16);
        test_random();
        test_back_to_back();
        test_scan(16);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
